// File: rtl/gnss_buf_pkg.sv
// Types and defaults shared by the GNSS sample-buffer capture writer and playback reader.
package gnss_buf_pkg;

   localparam int DEF_ADDR_W    = 14;
   localparam int DEF_WORD_BITS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } buf_state_t;

   // Travels with each fetched word so the output side knows where passes and the run end.
   typedef struct packed {
      logic eor;
      logic eop;
   } word_tag_t;

endpackage

// File: rtl/bit_serializer.sv
// Shifts one packed word out LSB first with a valid/ready handshake on each bit.
module bit_serializer #(
   parameter int WORD_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 load,
   input  logic [WORD_BITS-1:0] load_data,
   input  logic                 smp_ready,
   output logic                 smp_i,
   output logic                 smp_valid,
   output logic                 last_bit,
   output logic                 can_load
);

   localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

   logic [WORD_BITS-1:0] shreg_q;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic                 valid_q;
   logic                 accept;

   assign accept    = valid_q && smp_ready;
   assign last_bit  = (bit_cnt_q == CNT_W'(WORD_BITS - 1));
   // A new word may enter while the final bit of the current one is being accepted.
   assign can_load  = !valid_q || (accept && last_bit);
   assign smp_i     = shreg_q[0];
   assign smp_valid = valid_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         valid_q   <= 1'b0;
      end else if (clear) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         valid_q   <= 1'b0;
      end else if (load) begin
         shreg_q   <= load_data;
         bit_cnt_q <= '0;
         valid_q   <= 1'b1;
      end else if (accept) begin
         if (last_bit) begin
            valid_q <= 1'b0;
         end else begin
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sample_buf_reader.sv
// Replays packed 1-bit samples from BSRAM as a continuous bit stream, repeated for N passes.
module sample_buf_reader
   import gnss_buf_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int WORD_BITS = DEF_WORD_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    num_words,
   input  logic [7:0]           num_passes,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 ram_re,
   input  logic [WORD_BITS-1:0] ram_rdata,
   output logic                 smp_i,
   output logic                 smp_valid,
   input  logic                 smp_ready,
   output logic                 pass_done,
   output logic                 busy,
   output logic                 done
);

   buf_state_t           state_q, state_d;
   logic [ADDR_W-1:0]    nw_q, rd_addr_q;
   logic [7:0]           np_q, pass_cnt_q;
   logic                 more_q, more_d;
   logic                 rd_pend_q;
   word_tag_t            rd_tag_q;
   logic [WORD_BITS-1:0] pf_data_q;
   logic                 pf_valid_q;
   word_tag_t            pf_tag_q, sh_tag_q;
   logic                 pass_done_q, done_q;

   logic                 start_go, start_empty;
   logic                 can_load, last_bit;
   logic                 ser_load, pf_consume, pf_fill, issue, accept_last;
   word_tag_t            issue_tag;
   logic [WORD_BITS-1:0] load_data;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      start_go      = (state_q == IDLE) && start && !abort;
      start_empty   = start_go && ((num_words == '0) || (num_passes == '0));
      issue_tag.eop = (rd_addr_q == nw_q - ADDR_W'(1));
      issue_tag.eor = issue_tag.eop && (pass_cnt_q == np_q - 8'd1);
      ser_load      = (state_q != IDLE) && !abort && can_load && (pf_valid_q || rd_pend_q);
      pf_consume    = ser_load && pf_valid_q;
      // Returning data bypasses the prefetch register when the serializer can take it directly.
      pf_fill       = rd_pend_q && !(ser_load && !pf_valid_q);
      load_data     = pf_valid_q ? pf_data_q : ram_rdata;
      issue         = ((state_q == PRIME) || (state_q == STREAM)) && more_q && !rd_pend_q &&
                      (!pf_valid_q || pf_consume) && !abort;
      accept_last   = smp_valid && smp_ready && last_bit && !abort;
      more_d        = more_q;
      if (start_go && !start_empty) more_d = 1'b1;
      if (issue && issue_tag.eor)   more_d = 1'b0;
      if (abort)                    more_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_go && !start_empty) state_d = PRIME;
         PRIME:   if (ser_load) state_d = more_d ? STREAM : DRAIN;
         STREAM:  if (!more_d) state_d = DRAIN;
         DRAIN:   if (accept_last && sh_tag_q.eor) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nw_q        <= '0;
         np_q        <= '0;
         rd_addr_q   <= '0;
         pass_cnt_q  <= '0;
         more_q      <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_tag_q    <= '0;
         pass_done_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         more_q      <= more_d;
         rd_pend_q   <= issue;
         pass_done_q <= accept_last && sh_tag_q.eop;
         done_q      <= start_empty || (accept_last && sh_tag_q.eor);
         if (issue) rd_tag_q <= issue_tag;
         if (start_go) begin
            nw_q       <= num_words;
            np_q       <= num_passes;
            rd_addr_q  <= '0;
            pass_cnt_q <= '0;
         end else if (abort) begin
            rd_addr_q  <= '0;
            pass_cnt_q <= '0;
         end else if (issue) begin
            if (issue_tag.eor) begin
               rd_addr_q  <= '0;
               pass_cnt_q <= '0;
            end else if (issue_tag.eop) begin
               rd_addr_q  <= '0;
               pass_cnt_q <= pass_cnt_q + 8'd1;
            end else begin
               rd_addr_q  <= rd_addr_q + ADDR_W'(1);
            end
         end
      end
   end

   // NOTE: pf_data_q is an ordinary register, so it is reset with its valid flag; only RAM arrays go unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pf_data_q  <= '0;
         pf_valid_q <= 1'b0;
         pf_tag_q   <= '0;
         sh_tag_q   <= '0;
      end else begin
         if (abort) begin
            pf_valid_q <= 1'b0;
         end else if (pf_fill) begin
            pf_data_q  <= ram_rdata;
            pf_valid_q <= 1'b1;
            pf_tag_q   <= rd_tag_q;
         end else if (pf_consume) begin
            pf_valid_q <= 1'b0;
         end
         if (ser_load) sh_tag_q <= pf_valid_q ? pf_tag_q : rd_tag_q;
      end
   end

   bit_serializer #(
      .WORD_BITS (WORD_BITS)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .clear     (abort),
      .load      (ser_load),
      .load_data (load_data),
      .smp_ready (smp_ready),
      .smp_i     (smp_i),
      .smp_valid (smp_valid),
      .last_bit  (last_bit),
      .can_load  (can_load)
   );

   assign ram_addr  = rd_addr_q;
   assign ram_re    = issue;
   assign busy      = (state_q != IDLE);
   assign pass_done = pass_done_q;
   assign done      = done_q;

endmodule
